// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one ap_ctrl_hs FIR core across NUM_CH
// sample channels, with a watchdog that abandons a transaction the core never finishes.
module fir_channel_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   ch_sel,
    output logic [NUM_CH-1:0] done_pulse,
    output logic              busy,
    output logic              timeout,
    output logic [15:0]       frame_cnt
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [CH_W-1:0] last;
    logic [WD_W-1:0] wdog;
    logic [CH_W-1:0] cand;
    logic [CH_W-1:0] pick;
    logic            pick_valid;
    logic            core_finished;
    logic            wd_expired;

    // ap_idle is core status only; sequencing relies solely on the ready/done handshake.
    logic unused_status;
    assign unused_status = ap_idle;

    // Search starts one past the previous owner so every requester is reached within NUM_CH grants.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        cand       = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last) + k) % NUM_CH);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // In START the core must accept and finish together; in RUN ap_done alone completes.
    assign core_finished = (state == START) ? (ap_ready && ap_done)
                                            : ((state == RUN) && ap_done);
    assign wd_expired    = (wdog == WD_LAST);

    // NOTE: all state and outputs use non-blocking assignments so each register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last       <= CH_LAST;
            wdog       <= '0;
            ap_start   <= 1'b0;
            grant      <= '0;
            ch_sel     <= '0;
            done_pulse <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            done_pulse <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= START;
                        ch_sel   <= pick;
                        grant    <= NUM_CH'(1) << pick;
                        ap_start <= 1'b1;
                        busy     <= 1'b1;
                        wdog     <= '0;
                    end
                end
                START, RUN: begin
                    if (core_finished) begin
                        state      <= DONE;
                        ap_start   <= 1'b0;
                        done_pulse <= grant;
                        frame_cnt  <= frame_cnt + 16'd1;
                        last       <= ch_sel;
                    end else if (wd_expired) begin
                        // Abandon the hung core; the owner forfeits its turn.
                        state    <= IDLE;
                        ap_start <= 1'b0;
                        grant    <= '0;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                        last     <= ch_sel;
                    end else begin
                        if (state == START && ap_ready) begin
                            state    <= RUN;
                            ap_start <= 1'b0;
                        end
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level reference of the scheduler.
module tb_fir_channel_scheduler;

    localparam int NUM_CH      = 4;
    localparam int CH_W        = 2;
    localparam int TIMEOUT_CYC = 16;

    logic              clock    = 1'b0;
    logic              reset    = 1'b1;
    logic [NUM_CH-1:0] req      = '0;
    logic              ap_ready = 1'b0;
    logic              ap_done  = 1'b0;
    logic              ap_idle  = 1'b1;
    logic              ap_start;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   ch_sel;
    logic [NUM_CH-1:0] done_pulse;
    logic              busy;
    logic              timeout;
    logic [15:0]       frame_cnt;

    fir_channel_scheduler #(
        .NUM_CH     (NUM_CH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .ap_start  (ap_start),
        .ap_ready  (ap_ready),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .grant     (grant),
        .ch_sel    (ch_sel),
        .done_pulse(done_pulse),
        .busy      (busy),
        .timeout   (timeout),
        .frame_cnt (frame_cnt)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: who owns the core, whether the start handshake is still open,
    // whether this is the completion cycle, and how long the owner has held the core.
    int m_owner  = -1;
    bit m_hs     = 1'b0;
    bit m_fin    = 1'b0;
    int m_age    = 0;
    int m_last   = NUM_CH - 1;
    int m_chsel  = 0;
    bit m_to     = 1'b0;
    int m_frames = 0;

    always @(posedge clock) begin : model
        int c;
        if (reset) begin
            m_owner = -1; m_hs = 1'b0; m_fin = 1'b0; m_age = 0;
            m_last = NUM_CH - 1; m_chsel = 0; m_to = 1'b0; m_frames = 0;
        end else if (m_fin) begin
            m_fin   = 1'b0;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (m_last + k) % NUM_CH;
                if (m_owner < 0 && req[CH_W'(c)]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_hs    = 1'b1;
                m_age   = 0;
                m_chsel = m_owner;
            end
        end else if (m_hs ? (ap_ready && ap_done) : ap_done) begin
            m_fin    = 1'b1;
            m_hs     = 1'b0;
            m_frames = (m_frames + 1) % 65536;
            m_last   = m_owner;
        end else if (m_age == TIMEOUT_CYC - 1) begin
            m_to    = 1'b1;
            m_last  = m_owner;
            m_owner = -1;
            m_hs    = 1'b0;
        end else begin
            if (ap_ready) m_hs = 1'b0;
            m_age++;
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            check("cyc_ap_start",   32'(ap_start),   32'(m_hs));
            check("cyc_grant",      32'(grant),      (m_owner >= 0) ? (1 << m_owner) : 0);
            check("cyc_busy",       32'(busy),       32'(m_owner >= 0));
            check("cyc_ch_sel",     32'(ch_sel),     m_chsel);
            check("cyc_done_pulse", 32'(done_pulse), m_fin ? (1 << m_owner) : 0);
            check("cyc_timeout",    32'(timeout),    32'(m_to));
            check("cyc_frame_cnt",  32'(frame_cnt),  m_frames);
        end
    end

    // Core emulator: fixed or random ready/done latencies, optional hang per channel.
    int                ready_lat = 0;
    int                done_lat  = 0;
    logic [NUM_CH-1:0] hang_mask = '0;
    bit                rand_mode = 1'b0;
    int                start_k   = 0;
    int                run_k     = 0;
    bit                cur_hang  = 1'b0;

    always @(negedge clock) begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        ap_idle  = rand_mode ? 1'($urandom_range(0, 1)) : !busy;
        if (ap_start) begin
            if (start_k == 0) begin
                if (rand_mode) begin
                    ready_lat = int'($urandom_range(0, 3));
                    done_lat  = int'($urandom_range(0, 6));
                    cur_hang  = ($urandom_range(0, 7) == 0);
                end else begin
                    cur_hang = hang_mask[ch_sel];
                end
            end
            if (start_k == ready_lat) begin
                ap_ready = 1'b1;
                ap_done  = (done_lat == 0) && !cur_hang;
                run_k    = 0;
            end
            start_k++;
        end else begin
            start_k = 0;
            if (busy && done_pulse == '0) begin
                run_k++;
                if (run_k == done_lat && !cur_hang) ap_done = 1'b1;
            end else if (rand_mode) begin
                // Stray handshakes outside a transaction must be ignored.
                ap_ready = ($urandom_range(0, 3) == 0);
                ap_done  = ($urandom_range(0, 3) == 0);
            end
        end
    end

    int start_hi = 0;
    int busy_hi  = 0;
    int dp_cnt   = 0;
    int dp0_cnt  = 0;

    always @(negedge clock) begin
        if (ap_start) start_hi++;
        if (busy) busy_hi++;
        if (done_pulse != '0) dp_cnt++;
        if (done_pulse[0]) dp0_cnt++;
    end

    task automatic clear_mon();
        start_hi = 0; busy_hi = 0; dp_cnt = 0; dp0_cnt = 0;
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic bit cond_met(input int sel);
        case (sel)
            0:       return done_pulse != '0;
            1:       return timeout;
            default: return busy && !ap_start && grant == 4'b1000;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cond_met(sel) && n < budget);
        check({name, "_seen"}, 32'(cond_met(sel)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    int n;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        pulse_reset(3);
        cmp_on = 1'b1;
        check("init_busy", 32'(busy), 32'd0);

        // Single request on channel 2: ready after 2 cycles, done 10 cycles later.
        clear_mon();
        ready_lat = 2; done_lat = 10; hang_mask = '0;
        req = 4'b0100;
        wait_for(0, "single_done", 100, n);
        req = '0;
        check("single_latency",    n,                 32'd14);
        check("single_ch_sel",     32'(ch_sel),       32'd2);
        check("single_grant",      32'(grant),        32'b0100);
        check("single_done_pulse", 32'(done_pulse),   32'b0100);
        check("single_frame_cnt",  32'(frame_cnt),    32'd1);
        @(negedge clock);
        check("single_start_cycles", start_hi, 32'd3);
        check("single_pulse_cycles", dp_cnt,   32'd1);

        // Reset held 3 cycles in the middle of a transaction.
        req = 4'b0010;
        repeat (4) @(negedge clock);
        req = '0;
        pulse_reset(3);
        check("rst_ap_start",   32'(ap_start),   32'd0);
        check("rst_grant",      32'(grant),      32'd0);
        check("rst_done_pulse", 32'(done_pulse), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_timeout",    32'(timeout),    32'd0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        check("rst_ch_sel",     32'(ch_sel),     32'd0);

        // Fairness with every channel requesting.
        ready_lat = 0; done_lat = 5;
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            wait_for(0, "rr_done", 100, n);
            check("rr_order", 32'(ch_sel), rr_exp[i]);
            if (i == 5) req = '0;
        end
        check("rr_frame_cnt", 32'(frame_cnt), 32'd6);

        // Ready and done together on the first START cycle.
        @(negedge clock);
        clear_mon();
        ready_lat = 0; done_lat = 0;
        req = 4'b0001;
        wait_for(0, "fast_done", 20, n);
        req = '0;
        check("fast_latency",    n,                32'd2);
        check("fast_done_pulse", 32'(done_pulse),  32'b0001);
        @(negedge clock);
        check("fast_busy_cycles",  busy_hi,         32'd2);
        check("fast_start_cycles", start_hi,        32'd1);
        check("fast_frame_cnt",    32'(frame_cnt),  32'd7);

        // Watchdog: channel 0 hangs, channel 1 must be served next.
        pulse_reset(2);
        clear_mon();
        ready_lat = 1; done_lat = 3; hang_mask = 4'b0001;
        req = 4'b0011;
        wait_for(1, "wd_timeout", 100, n);
        check("wd_latency",     n,                32'd17);
        check("wd_busy_cycles", busy_hi,          32'd16);
        check("wd_frame_cnt",   32'(frame_cnt),   32'd0);
        check("wd_grant",       32'(grant),       32'd0);
        wait_for(0, "wd_next_done", 100, n);
        req = '0;
        check("wd_next_pulse",   32'(done_pulse), 32'b0010);
        check("wd_next_ch_sel",  32'(ch_sel),     32'd1);
        check("wd_next_frames",  32'(frame_cnt),  32'd1);
        check("wd_sticky",       32'(timeout),    32'd1);
        @(negedge clock);
        check("wd_no_pulse0", dp0_cnt, 32'd0);

        // Reset while channel 3 is in RUN; channel 0 must win first afterwards.
        hang_mask = '0; ready_lat = 0; done_lat = 20;
        req = 4'b1001;
        wait_for(2, "mid_run_ch3", 50, n);
        check("mid_run_grant", 32'(grant), 32'b1000);
        pulse_reset(2);
        done_lat = 3;
        wait_for(0, "post_rst_first", 50, n);
        check("post_rst_first_ch", 32'(ch_sel), 32'd0);
        wait_for(0, "post_rst_second", 50, n);
        req = '0;
        check("post_rst_second_ch", 32'(ch_sel), 32'd3);

        // Randomized traffic with random latencies, hangs, stray handshakes and resets.
        rand_mode = 1'b1;
        pulse_reset(2);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) req = NUM_CH'($urandom);
            reset = ($urandom_range(0, 599) == 0);
        end
        @(negedge clock);
        reset = 1'b0;
        req = '0;
        rand_mode = 1'b0;
        repeat (40) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Time-multiplexes one HLS FIR core (ap_ctrl_hs: ap_start/ap_ready/ap_done/ap_idle) across NUM_CH independent sample channels in the multirate filter chain. Fair round-robin arbitration between channel requests, one core transaction per grant. Drives the channel-select index that steers the datapath's per-channel state and coefficient bank, and reports per-channel completion. A watchdog aborts a hung transaction.

## Interface
- NUM_CH, 4, number of requesting channels (≥2)
- CH_W, $clog2(NUM_CH), width of channel index (derived, do not override)
- TIMEOUT_CYC, 4096, max cycles from ap_start to ap_done before abort (≥2)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel request; must be held until that channel's done_pulse
- ap_start  out  1  to FIR core
- ap_ready  in  1  from FIR core; core accepted the start
- ap_done  in  1  from FIR core; transaction complete
- ap_idle  in  1  from FIR core; status only, not used for sequencing
- grant  out  NUM_CH  one-hot owner of the core; zero when idle
- ch_sel  out  CH_W  index of granted channel; stable for whole transaction
- done_pulse  out  NUM_CH  one-cycle completion strobe for granted channel
- busy  out  1  high in any state other than IDLE
- timeout  out  1  sticky; set on watchdog abort, cleared only by reset
- frame_cnt  out  16  completed-transaction count, wraps 0xFFFF→0

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: if req≠0, choose first set req bit searching from last+1 upward, modulo NUM_CH. Register ch_sel and grant. Go to START. With req=0, stay in IDLE.
- START: ap_start=1. Stay in START until ap_ready=1 is sampled.
  - ap_ready=1 and ap_done=1 in the same cycle → DONE.
  - ap_ready=1 only → RUN.
- RUN: ap_start=0. Wait for ap_done=1, then go to DONE.
- DONE: done_pulse[ch_sel]=1 for this cycle only. frame_cnt increments. last←ch_sel. grant clears at exit. Go to IDLE.
- Watchdog: a counter clears on entry to START and increments every cycle in START/RUN. If it reaches TIMEOUT_CYC−1 with no ap_done:
  - set timeout=1, last←ch_sel, go to IDLE.
  - No done_pulse. frame_cnt is not incremented.
  - The aborted channel loses its turn; recovering the core is the system's job.
- If req[ch_sel] drops mid-transaction, the transaction still completes normally.
- Requests never preempt a running transaction.
- ap_idle is ignored for sequencing.
- Reset, at any time including mid-transaction:
  - next state is IDLE; ap_start, grant, done_pulse, busy, timeout, ch_sel, frame_cnt and watchdog all go to 0.
  - last←NUM_CH−1, so channel 0 has first priority.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from req/ap_* to any output.
- req rising in IDLE → grant/ch_sel/busy valid the next cycle, with ap_start=1 in that same cycle (START).
- ap_start stays high from START entry through the cycle in which ap_ready is sampled. It is low the following cycle.
- ap_done sampled in RUN → done_pulse in the next cycle (DONE). Then IDLE one cycle later.
- Minimum transaction with ap_ready and ap_done both high in the first START cycle: IDLE→START→DONE→IDLE, 3 cycles.
- Back-to-back grants are separated by exactly one IDLE cycle.
- Round-robin guarantee: a continuously asserted req is granted within NUM_CH transactions.
- ap_done while in IDLE or DONE is ignored.

## Test plan
- Reset: assert reset 3 cycles mid-stream → next cycle ap_start=0, grant=0, done_pulse=0, busy=0, timeout=0, frame_cnt=0, ch_sel=0.
- Single request: req=4'b0100, core gives ap_ready 2 cycles after ap_start and ap_done 10 cycles later → ch_sel=2, grant=4'b0100, ap_start high exactly 3 cycles, done_pulse=4'b0100 for 1 cycle, frame_cnt=1.
- Fairness: req=4'b1111 held, core latency 5 → grant order 0,1,2,3,0,1 with one IDLE gap between grants; frame_cnt=6 after six done pulses.
- Same-cycle handshake: ap_ready=ap_done=1 on first START cycle → FSM skips RUN, done_pulse on the next cycle, total 3 cycles.
- Watchdog: TIMEOUT_CYC=16, req=4'b0011, ap_done never asserted for channel 0 → abort after 16 cycles, timeout=1 sticky, no done_pulse[0], channel 1 granted next, frame_cnt unchanged.
- Reset mid-RUN on channel 3: req=4'b1001 held → after reset release, channel 0 is granted first, then channel 3.
